ifu_fetch: RTL and testbench

Instruction fetch unit sitting upstream of the decode stage. It owns the PC, issues sequential word fetches on the instruction bus, and buffers returned words in a small in-order prefetch FIFO. It presents instruction/address pairs to decode and redirects on the jump flag from execute, discarding stale in-flight responses.

---
 rtl/ifu_fetch.sv | 140 ++++++++++++++
 tb/tb_ifu_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: owns the PC, issues sequential word fetches and buffers
// returned words in an in-order prefetch FIFO feeding decode, with jump redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_flag_i,
    input  logic [31:0] jump_addr_i,
    input  logic        hold_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_addr_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0001;

    logic [31:0]   pc_q, pc_d;
    logic [31:0]   fifo_addr_q [FIFO_DEPTH];
    logic [31:0]   fifo_data_q [FIFO_DEPTH];
    logic [AW-1:0] f_wr_q, f_wr_d, f_rd_q, f_rd_d;
    logic [CW-1:0] count_q, count_d;
    logic [31:0]   aq_q [FIFO_DEPTH];
    logic [AW-1:0] aq_wr_q, aq_wr_d, aq_rd_q, aq_rd_d;
    logic [CW-1:0] outst_q, outst_d;
    logic [CW-1:0] drop_q, drop_d;

    logic        issue;
    logic        rv_drop;
    logic        rv_live;
    logic        pop;
    logic [CW:0] used;

    // Credit uses registered occupancy only; a pop this cycle frees a slot next cycle.
    always_comb begin
        used         = {1'b0, count_q} + {1'b0, outst_q};
        ibus_req_o   = !rst && !jump_flag_i && (used < DEPTH_W);
        ibus_addr_o  = pc_q;
        inst_valid_o = (count_q != '0);
        inst_o       = inst_valid_o ? fifo_data_q[f_rd_q] : NOP;
        inst_addr_o  = inst_valid_o ? fifo_addr_q[f_rd_q] : '0;
        issue        = ibus_req_o && ibus_gnt_i;
        rv_drop      = ibus_rvalid_i && (drop_q != '0);
        rv_live      = ibus_rvalid_i && (drop_q == '0) && (outst_q != '0);
        pop          = inst_valid_o && !hold_i;
    end

    always_comb begin
        pc_d    = pc_q;
        f_wr_d  = f_wr_q;
        f_rd_d  = f_rd_q;
        count_d = count_q;
        aq_wr_d = aq_wr_q;
        aq_rd_d = aq_rd_q;
        outst_d = outst_q;
        drop_d  = drop_q;
        if (jump_flag_i) begin
            // Everything still on the bus turns into responses to be discarded.
            pc_d    = jump_addr_i;
            f_wr_d  = '0;
            f_rd_d  = '0;
            count_d = '0;
            aq_wr_d = '0;
            aq_rd_d = '0;
            outst_d = '0;
            drop_d  = drop_q + outst_q - CW'(rv_drop) - CW'(rv_live);
        end else begin
            if (issue) begin
                pc_d    = pc_q + 32'd4;
                aq_wr_d = aq_wr_q + AW'(1);
            end
            if (rv_live) begin
                aq_rd_d = aq_rd_q + AW'(1);
                f_wr_d  = f_wr_q + AW'(1);
            end
            if (pop) begin
                f_rd_d = f_rd_q + AW'(1);
            end
            if (rv_drop) begin
                drop_d = drop_q - CW'(1);
            end
            outst_d = outst_q + CW'(issue) - CW'(rv_live);
            count_d = count_q + CW'(rv_live) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            f_wr_q  <= '0;
            f_rd_q  <= '0;
            count_q <= '0;
            aq_wr_q <= '0;
            aq_rd_q <= '0;
            outst_q <= '0;
            drop_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            f_wr_q  <= f_wr_d;
            f_rd_q  <= f_rd_d;
            count_q <= count_d;
            aq_wr_q <= aq_wr_d;
            aq_rd_q <= aq_rd_d;
            outst_q <= outst_d;
            drop_q  <= drop_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !jump_flag_i) begin
            if (issue) begin
                aq_q[aq_wr_q] <= pc_q;
            end
            if (rv_live) begin
                fifo_addr_q[f_wr_q] <= aq_q[aq_rd_q];
                fifo_data_q[f_wr_q] <= ibus_rdata_i;
            end
        end
    end

`ifndef SYNTHESIS
    // A grant during a redirect cycle is tolerated and ignored.
    a_gnt_without_req: assert property (@(posedge clk) disable iff (rst)
        !(ibus_gnt_i && !ibus_req_o && !jump_flag_i))
        else $error("ifu_fetch: grant without request");
    a_unmatched_rvalid: assert property (@(posedge clk) disable iff (rst)
        !(ibus_rvalid_i && (outst_q == '0) && (drop_q == '0)))
        else $error("ifu_fetch: rvalid with nothing outstanding");
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: bus responder with selectable latency and an
// in-order expected address stream for requests and delivered instructions.
module tb_ifu_fetch;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic        hold;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic        ibus_gnt;
    logic        ibus_rvalid;
    logic [31:0] ibus_rdata;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_addr;

    logic        force_gnt;
    logic [1:0]  lsel;
    logic [2:0]  pv;
    logic [31:0] pd [3];

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_req;
    logic [31:0] exp_inst;

    ifu_fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .hold_i       (hold),
        .ibus_req_o   (ibus_req),
        .ibus_addr_o  (ibus_addr),
        .ibus_gnt_i   (ibus_gnt),
        .ibus_rvalid_i(ibus_rvalid),
        .ibus_rdata_i (ibus_rdata),
        .inst_valid_o (inst_valid),
        .inst_o       (inst),
        .inst_addr_o  (inst_addr)
    );

    always #5 clk = ~clk;

    // Responder: zero-wait grants, data = addr ^ KEY returned 1..3 cycles later.
    assign ibus_gnt    = ibus_req | force_gnt;
    assign ibus_rvalid = pv[lsel];
    assign ibus_rdata  = pd[lsel];

    always @(posedge clk) begin
        if (rst) begin
            pv <= '0;
        end else begin
            pv    <= {pv[1:0], ibus_req & ibus_gnt};
            pd[0] <= ibus_addr ^ KEY;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: check the current cycle against the expected streams, then advance.
    task automatic cyc();
        #1;
        if (!rst) begin
            if (ibus_req && ibus_gnt && !jump_flag) begin
                check("req_addr", ibus_addr, exp_req);
                exp_req += 32'd4;
            end
            if (inst_valid) begin
                check("inst_addr", inst_addr, exp_inst);
                check("inst_data", inst, exp_inst ^ KEY);
                if (!hold && !jump_flag) exp_inst += 32'd4;
            end else begin
                check("idle_inst", inst, 32'h0000_0001);
                check("idle_addr", inst_addr, 32'h0);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inst(input string tag, input logic [31:0] a, input int lim);
        int n = 0;
        while (!(inst_valid && inst_addr == a) && n < lim) begin
            cyc();
            n++;
        end
        check(tag, 32'(inst_valid && inst_addr == a), 32'd1);
    endtask

    task automatic do_reset(input logic [1:0] lat);
        rst       = 1'b1;
        jump_flag = 1'b0;
        hold      = 1'b0;
        force_gnt = 1'b0;
        lsel      = lat;
        repeat (2) cyc();
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_inst", inst, 32'h0000_0001);
        check("rst_iaddr", inst_addr, 32'h0);
        check("rst_req", 32'(ibus_req), 32'd0);
        check("rst_baddr", ibus_addr, RESET_PC);
        exp_req  = RESET_PC;
        exp_inst = RESET_PC;
        rst      = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        jump_flag = 1'b0;
        jump_addr = '0;
        hold      = 1'b0;
        force_gnt = 1'b0;
        lsel      = 2'd0;
        exp_req   = RESET_PC;
        exp_inst  = RESET_PC;
        @(posedge clk);
        #1;

        // Reset and free-running stream with one-cycle response latency.
        do_reset(2'd0);
        #1;
        check("first_req", 32'(ibus_req), 32'd1);
        check("first_addr", ibus_addr, RESET_PC);
        cyc();
        check("c1_valid", 32'(inst_valid), 32'd0);
        cyc();
        check("c2_valid", 32'(inst_valid), 32'd1);
        wait_inst("stream", 32'h40, 60);

        // Decode stall: credit fills, head held, then resumes without gaps.
        hold = 1'b1;
        repeat (5) cyc();
        check("hold_req", 32'(ibus_req), 32'd0);
        check("hold_valid", 32'(inst_valid), 32'd1);
        hold = 1'b0;
        repeat (8) cyc();

        // Redirect with two requests in flight (three-cycle latency).
        do_reset(2'd2);
        cyc();
        cyc();
        check("full_credit_req", 32'(ibus_req), 32'd0);
        jump_flag = 1'b1;
        jump_addr = 32'h0000_0100;
        cyc();
        jump_flag = 1'b0;
        exp_req   = 32'h0000_0100;
        exp_inst  = 32'h0000_0100;
        #1;
        check("jmp_req", 32'(ibus_req), 32'd1);
        check("jmp_addr", ibus_addr, 32'h0000_0100);
        check("jmp_valid", 32'(inst_valid), 32'd0);
        wait_inst("jmp_first", 32'h0000_0100, 20);
        repeat (10) cyc();

        // Redirect coinciding with a grant and a live response.
        do_reset(2'd0);
        cyc();
        jump_flag = 1'b1;
        force_gnt = 1'b1;
        jump_addr = 32'h0000_0200;
        #1;
        check("jg_req", 32'(ibus_req), 32'd0);
        cyc();
        jump_flag = 1'b0;
        force_gnt = 1'b0;
        exp_req   = 32'h0000_0200;
        exp_inst  = 32'h0000_0200;
        #1;
        check("jg_req2", 32'(ibus_req), 32'd1);
        check("jg_addr", ibus_addr, 32'h0000_0200);
        check("jg_valid", 32'(inst_valid), 32'd0);
        wait_inst("jg_first", 32'h0000_0200, 10);
        repeat (6) cyc();

        // PC wrap past the top of the address space.
        jump_flag = 1'b1;
        jump_addr = 32'hFFFF_FFF8;
        cyc();
        jump_flag = 1'b0;
        exp_req   = 32'hFFFF_FFF8;
        exp_inst  = 32'hFFFF_FFF8;
        wait_inst("wrap_top", 32'hFFFF_FFFC, 20);
        wait_inst("wrap_zero", 32'h0, 10);
        repeat (4) cyc();

        // Reset with buffered and in-flight words.
        hold = 1'b1;
        repeat (4) cyc();
        rst  = 1'b1;
        hold = 1'b0;
        cyc();
        check("mrst_valid", 32'(inst_valid), 32'd0);
        check("mrst_inst", inst, 32'h0000_0001);
        check("mrst_req", 32'(ibus_req), 32'd0);
        rst      = 1'b0;
        exp_req  = RESET_PC;
        exp_inst = RESET_PC;
        #1;
        check("mrst_restart_req", 32'(ibus_req), 32'd1);
        check("mrst_restart_addr", ibus_addr, RESET_PC);
        wait_inst("mrst_stream", 32'h8, 20);
        repeat (3) cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
